// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: bundles the ID-side request and the per-stage control outputs
// of the pipelined control unit.
//
// Handshake: id_valid qualifies id_inst. The ID instruction is accepted into EX
// on a rising edge where stall_i=0, flush_i=0 and hazard_stall=0; hazard_stall
// is the inverse of ready, and the producer (IF/ID) must hold id_inst/id_valid
// while it is high. stall_i freezes every stage and overrides all else.
//
// Signals (slave = ctrl_pipe, master = IF/ID + datapath side):
//   id_inst, id_valid, stall_i, flush_i           master -> slave
//   hazard_stall                                  slave -> master (combinational)
//   {ex,mem,wb}_valid/_ctrl/_rd                   slave -> master
//   fwd_a, fwd_b                                  slave -> master (CTRL_FWD_EN only)
// Optional feature macro: CTRL_FWD_EN.
interface ctrl_pipe_if #(
    parameter int INST_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5
);
    localparam int CTRL_W = 18;

    logic [INST_WIDTH-1:0]    id_inst;
    logic                     id_valid;
    logic                     stall_i;
    logic                     flush_i;
    logic                     hazard_stall;
    logic                     ex_valid;
    logic                     mem_valid;
    logic                     wb_valid;
    logic [CTRL_W-1:0]        ex_ctrl;
    logic [CTRL_W-1:0]        mem_ctrl;
    logic [CTRL_W-1:0]        wb_ctrl;
    logic [RF_ADDR_WIDTH-1:0] ex_rd;
    logic [RF_ADDR_WIDTH-1:0] mem_rd;
    logic [RF_ADDR_WIDTH-1:0] wb_rd;
`ifdef CTRL_FWD_EN
    logic [1:0]               fwd_a;
    logic [1:0]               fwd_b;

    modport master (
        output id_inst, id_valid, stall_i, flush_i,
        input  hazard_stall, ex_valid, mem_valid, wb_valid,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
        input  fwd_a, fwd_b
    );
    modport slave (
        input  id_inst, id_valid, stall_i, flush_i,
        output hazard_stall, ex_valid, mem_valid, wb_valid,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
        output fwd_a, fwd_b
    );
`else
    modport master (
        output id_inst, id_valid, stall_i, flush_i,
        input  hazard_stall, ex_valid, mem_valid, wb_valid,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd
    );
    modport slave (
        input  id_inst, id_valid, stall_i, flush_i,
        output hazard_stall, ex_valid, mem_valid, wb_valid,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd
    );
`endif
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit. Decodes the ID instruction into an 18-bit
// control bundle and carries {valid, ctrl, rd} through EX, MEM and WB. Detects
// RAW hazards between ID sources and in-flight destinations and raises
// hazard_stall; inserts bubbles on hazard, flush or invalid ID.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   ctrl_pipe_if.slave (ID inputs, stall/flush, stage outputs, forwarding)
//
// Bundle: [17] reg_write [16] mem_write [15] mem_read [14:13] mem_to_reg
//         [12] utype_src [11] jtype_src [10] jalr_src [9] branch [8] jump
//         [7:6] alu_op [5:4] alu_src_a [3:2] alu_src_b [1] csr_we [0] csr_rd
//
// Optional feature macro: CTRL_FWD_EN. When defined, only load-use stalls are
// requested and fwd_a/fwd_b select EX operand forwarding from MEM (10) or WB
// (01). When undefined, any valid writer in EX or MEM stalls a dependent ID.
module ctrl_pipe #(
    parameter int INST_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_pipe_if.slave   bus
);
    localparam int CTRL_W = 18;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARI_I  = 7'b0010011;
    localparam logic [6:0] OP_ARI_R  = 7'b0110011;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    // ---------------- ID decode ----------------
    logic [6:0]               opcode;
    logic [RF_ADDR_WIDTH-1:0] id_rd;
    logic [RF_ADDR_WIDTH-1:0] id_rs1;
    logic [RF_ADDR_WIDTH-1:0] id_rs2;
    logic                     funct3_msb;

    assign opcode     = bus.id_inst[6:0];
    assign id_rd      = bus.id_inst[7 +: RF_ADDR_WIDTH];
    assign id_rs1     = bus.id_inst[15 +: RF_ADDR_WIDTH];
    assign id_rs2     = bus.id_inst[20 +: RF_ADDR_WIDTH];
    assign funct3_msb = bus.id_inst[14];

    // Immediate/funct bits play no part in control decode.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{bus.id_inst[INST_WIDTH-1:25], bus.id_inst[13:12]};

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_ari_i, is_ari_r, is_csr;

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_ari_i  = (opcode == OP_ARI_I);
    assign is_ari_r  = (opcode == OP_ARI_R);
    assign is_csr    = (opcode == OP_CSR);

    logic       rd_nz;
    logic       known_op;
    logic       reg_write;
    logic       utype_src;
    logic       jump;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [CTRL_W-1:0] dec_ctrl;

    assign rd_nz     = (id_rd != '0);
    assign known_op  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_ari_i | is_ari_r | is_csr;
    // Unknown opcodes leave every is_* flag low, so the bundle is all zero.
    assign reg_write = known_op & ~is_branch & ~is_store & rd_nz;
    assign utype_src = is_auipc | is_jal | is_jalr;
    assign jump      = is_jal | is_jalr;

    assign mem_to_reg = is_csr   ? 2'b01 :
                        is_load  ? 2'b10 : 2'b00;
    assign alu_op     = is_ari_i ? 2'b11 :
                        is_ari_r ? 2'b10 :
                        is_branch ? 2'b01 : 2'b00;
    assign alu_src_a  = (is_lui | utype_src) ? 2'b01 : 2'b00;
    assign alu_src_b  = (is_load | is_store | is_ari_i | is_lui | is_auipc | jump)
                        ? 2'b01 : 2'b00;

    assign dec_ctrl = {reg_write, is_store, is_load, mem_to_reg, utype_src,
                       jump, is_jalr, is_branch, jump, alu_op, alu_src_a,
                       alu_src_b, is_csr, is_csr & rd_nz};

    // Source use; x0 never creates a dependency.
    logic use_rs1;
    logic use_rs2;
    assign use_rs1 = (is_jalr | is_branch | is_load | is_store | is_ari_i |
                      is_ari_r | (is_csr & ~funct3_msb)) & (id_rs1 != '0);
    assign use_rs2 = (is_branch | is_store | is_ari_r) & (id_rs2 != '0);

    // ---------------- stage registers ----------------
    logic                     ex_valid_q, mem_valid_q, wb_valid_q;
    logic [CTRL_W-1:0]        ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
    logic [RF_ADDR_WIDTH-1:0] ex_rd_q, mem_rd_q, wb_rd_q;

    // ---------------- hazard detection ----------------
    logic raw;
`ifdef CTRL_FWD_EN
    // Only a load in EX cannot be covered by forwarding.
    assign raw = ex_valid_q & ex_ctrl_q[15] &
                 ((use_rs1 & (ex_rd_q == id_rs1)) | (use_rs2 & (ex_rd_q == id_rs2)));
`else
    logic ex_writes;
    logic mem_writes;
    assign ex_writes  = ex_valid_q & ex_ctrl_q[17];
    assign mem_writes = mem_valid_q & mem_ctrl_q[17];
    assign raw = (use_rs1 & ((ex_writes  & (ex_rd_q  == id_rs1)) |
                             (mem_writes & (mem_rd_q == id_rs1)))) |
                 (use_rs2 & ((ex_writes  & (ex_rd_q  == id_rs2)) |
                             (mem_writes & (mem_rd_q == id_rs2))));
`endif

    logic hazard_stall;
    logic bubble;
    assign hazard_stall = ~rst & bus.id_valid & ~bus.flush_i & raw;
    assign bubble       = bus.flush_i | hazard_stall | ~bus.id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            mem_ctrl_q  <= '0;
            wb_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
        end else if (!bus.stall_i) begin
            wb_valid_q  <= mem_valid_q;
            wb_ctrl_q   <= mem_ctrl_q;
            wb_rd_q     <= mem_rd_q;
            mem_valid_q <= ex_valid_q;
            mem_ctrl_q  <= ex_ctrl_q;
            mem_rd_q    <= ex_rd_q;
            if (bubble) begin
                ex_valid_q <= 1'b0;
                ex_ctrl_q  <= '0;
                ex_rd_q    <= '0;
            end else begin
                ex_valid_q <= 1'b1;
                ex_ctrl_q  <= dec_ctrl;
                ex_rd_q    <= id_rd;
            end
        end
    end

`ifdef CTRL_FWD_EN
    // EX sources; stored as x0 when unused or bubbled so they never forward.
    logic [RF_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else if (!bus.stall_i) begin
            if (bubble) begin
                ex_rs1_q <= '0;
                ex_rs2_q <= '0;
            end else begin
                ex_rs1_q <= use_rs1 ? id_rs1 : '0;
                ex_rs2_q <= use_rs2 ? id_rs2 : '0;
            end
        end
    end

    logic mem_fwd_ok, wb_fwd_ok;
    assign mem_fwd_ok = ex_valid_q & mem_valid_q & mem_ctrl_q[17];
    assign wb_fwd_ok  = ex_valid_q & wb_valid_q  & wb_ctrl_q[17];

    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (!rst) begin
            if (mem_fwd_ok && ex_rs1_q != '0 && mem_rd_q == ex_rs1_q)
                bus.fwd_a = 2'b10;
            else if (wb_fwd_ok && ex_rs1_q != '0 && wb_rd_q == ex_rs1_q)
                bus.fwd_a = 2'b01;
            if (mem_fwd_ok && ex_rs2_q != '0 && mem_rd_q == ex_rs2_q)
                bus.fwd_b = 2'b10;
            else if (wb_fwd_ok && ex_rs2_q != '0 && wb_rd_q == ex_rs2_q)
                bus.fwd_b = 2'b01;
        end
    end
`endif

    assign bus.hazard_stall = hazard_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.mem_ctrl     = mem_ctrl_q;
    assign bus.wb_ctrl      = wb_ctrl_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.wb_rd        = wb_rd_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe. A decode table checks the EX
// bundle for each instruction class; hand sequences cover reset, latency,
// load-use and ALU RAW stalls, flush priority and external freeze.
module tb_ctrl_pipe;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARI_I  = 7'b0010011;
    localparam logic [6:0] OP_ARI_R  = 7'b0110011;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.INST_WIDTH(32), .RF_ADDR_WIDTH(5)) bus ();

    ctrl_pipe #(.INST_WIDTH(32), .RF_ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, rd, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] inst, input logic valid, input logic flush);
        bus.id_inst  = inst;
        bus.id_valid = valid;
        bus.flush_i  = flush;
    endtask

    task automatic idle_drain();
        drive(32'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    // Holds the current ID instruction until it issues; returns stall cycles.
    task automatic count_stalls(output int stalls);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!bus.hazard_stall) break;
            stalls++;
            tick();
        end
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        flush;
        logic        exp_v;
        logic [17:0] exp_ctrl;
        logic [4:0]  exp_rd;
        string       name;
    } vec_t;

    vec_t vecs[15];

    int exp_ld_stalls;
    int exp_alu_stalls;
    int stalls;

    initial begin
`ifdef CTRL_FWD_EN
        exp_ld_stalls  = 1;
        exp_alu_stalls = 0;
`else
        exp_ld_stalls  = 2;
        exp_alu_stalls = 2;
`endif
        vecs[0]  = '{enc(OP_ARI_I, 5'd1, 3'd0, 5'd0, 5'd5), 1, 0, 1, 18'h200C4, 5'd1, "addi"};
        vecs[1]  = '{enc(OP_ARI_R, 5'd3, 3'd0, 5'd2, 5'd4), 1, 0, 1, 18'h20080, 5'd3, "add"};
        vecs[2]  = '{enc(OP_LOAD,  5'd2, 3'd2, 5'd1, 5'd0), 1, 0, 1, 18'h2C004, 5'd2, "lw"};
        vecs[3]  = '{enc(OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2), 1, 0, 1, 18'h10004, 5'd0, "sw"};
        vecs[4]  = '{enc(OP_BRANCH,5'd0, 3'd0, 5'd0, 5'd0), 1, 0, 1, 18'h00240, 5'd0, "beq"};
        vecs[5]  = '{enc(OP_LUI,   5'd5, 3'd0, 5'd0, 5'd0), 1, 0, 1, 18'h20014, 5'd5, "lui"};
        vecs[6]  = '{enc(OP_AUIPC, 5'd6, 3'd0, 5'd0, 5'd0), 1, 0, 1, 18'h21014, 5'd6, "auipc"};
        vecs[7]  = '{enc(OP_JAL,   5'd1, 3'd0, 5'd0, 5'd0), 1, 0, 1, 18'h21914, 5'd1, "jal"};
        vecs[8]  = '{enc(OP_JALR,  5'd1, 3'd0, 5'd0, 5'd0), 1, 0, 1, 18'h21D14, 5'd1, "jalr"};
        vecs[9]  = '{enc(OP_CSR,   5'd7, 3'd1, 5'd3, 5'd0), 1, 0, 1, 18'h22003, 5'd7, "csrrw_x7"};
        vecs[10] = '{enc(OP_CSR,   5'd0, 3'd1, 5'd3, 5'd0), 1, 0, 1, 18'h02002, 5'd0, "csrrw_x0"};
        vecs[11] = '{enc(OP_ARI_R, 5'd0, 3'd0, 5'd1, 5'd2), 1, 0, 1, 18'h00080, 5'd0, "add_x0"};
        vecs[12] = '{enc(7'h7F,    5'd9, 3'd0, 5'd0, 5'd0), 1, 0, 1, 18'h00000, 5'd9, "unknown"};
        vecs[13] = '{enc(OP_ARI_I, 5'd1, 3'd0, 5'd0, 5'd5), 0, 0, 0, 18'h00000, 5'd0, "invalid_id"};
        vecs[14] = '{enc(OP_ARI_I, 5'd4, 3'd0, 5'd0, 5'd5), 1, 1, 0, 18'h00000, 5'd0, "flushed"};

        // ---- reset with id_valid high ----
        rst = 1'b1;
        bus.stall_i = 1'b0;
        drive(vecs[0].inst, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_ex_valid",  {31'd0, bus.ex_valid}, 0);
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 0);
        chk("rst_wb_valid",  {31'd0, bus.wb_valid}, 0);
        chk("rst_ex_ctrl",   {14'd0, bus.ex_ctrl}, 0);
        chk("rst_wb_ctrl",   {14'd0, bus.wb_ctrl}, 0);
        chk("rst_hazard",    {31'd0, bus.hazard_stall}, 0);
        rst = 1'b0;
        idle_drain();

        // ---- decode table ----
        foreach (vecs[i]) begin
            drive(vecs[i].inst, vecs[i].valid, vecs[i].flush);
            #1;
            chk({vecs[i].name, "_hazard"}, {31'd0, bus.hazard_stall}, 0);
            tick();
            chk({vecs[i].name, "_ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, vecs[i].exp_v});
            chk({vecs[i].name, "_ex_ctrl"},  {14'd0, bus.ex_ctrl}, {14'd0, vecs[i].exp_ctrl});
            chk({vecs[i].name, "_ex_rd"},    {27'd0, bus.ex_rd}, {27'd0, vecs[i].exp_rd});
            idle_drain();
        end

        // ---- latency: addi x1 reaches WB three edges after ID ----
        drive(vecs[0].inst, 1'b1, 1'b0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("lat_ex_ctrl", {14'd0, bus.ex_ctrl}, 32'h200C4);
        tick();
        chk("lat_mem_valid", {31'd0, bus.mem_valid}, 1);
        chk("lat_wb_valid_early", {31'd0, bus.wb_valid}, 0);
        tick();
        chk("lat_wb_valid", {31'd0, bus.wb_valid}, 1);
        chk("lat_wb_ctrl", {14'd0, bus.wb_ctrl}, 32'h200C4);
        chk("lat_wb_rd", {27'd0, bus.wb_rd}, 1);
        tick();
        chk("lat_wb_drained", {31'd0, bus.wb_valid}, 0);
        idle_drain();

        // ---- load-use: lw x2 then add x3,x2,x4 ----
        drive(enc(OP_LOAD, 5'd2, 3'd2, 5'd1, 5'd0), 1'b1, 1'b0);
        tick();
        drive(enc(OP_ARI_R, 5'd3, 3'd0, 5'd2, 5'd4), 1'b1, 1'b0);
        count_stalls(stalls);
        chk("ld_use_stalls", stalls, exp_ld_stalls);
        chk("ld_use_ex_bubble", {31'd0, bus.ex_valid}, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("ld_use_add_ctrl", {14'd0, bus.ex_ctrl}, 32'h20080);
        chk("ld_use_add_rd", {27'd0, bus.ex_rd}, 3);
`ifdef CTRL_FWD_EN
        chk("ld_use_fwd_a", {30'd0, bus.fwd_a}, 1);
        chk("ld_use_fwd_b", {30'd0, bus.fwd_b}, 0);
`endif
        idle_drain();

        // ---- ALU RAW: addi x1 then add x5,x1,x1 ----
        drive(vecs[0].inst, 1'b1, 1'b0);
        tick();
        drive(enc(OP_ARI_R, 5'd5, 3'd0, 5'd1, 5'd1), 1'b1, 1'b0);
        count_stalls(stalls);
        chk("alu_raw_stalls", stalls, exp_alu_stalls);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("alu_raw_ex_ctrl", {14'd0, bus.ex_ctrl}, 32'h20080);
        chk("alu_raw_ex_rd", {27'd0, bus.ex_rd}, 5);
`ifdef CTRL_FWD_EN
        chk("alu_raw_fwd_a", {30'd0, bus.fwd_a}, 2);
        chk("alu_raw_fwd_b", {30'd0, bus.fwd_b}, 2);
`endif
        idle_drain();

        // ---- flush beats hazard: lw x1 in EX, jalr x2,0(x1) in ID ----
        drive(enc(OP_LOAD, 5'd1, 3'd2, 5'd0, 5'd0), 1'b1, 1'b0);
        tick();
        drive(enc(OP_JALR, 5'd2, 3'd0, 5'd1, 5'd0), 1'b1, 1'b0);
        #1;
        chk("flush_pre_hazard", {31'd0, bus.hazard_stall}, 1);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_hazard", {31'd0, bus.hazard_stall}, 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("flush_ex_valid", {31'd0, bus.ex_valid}, 0);
        chk("flush_ex_ctrl", {14'd0, bus.ex_ctrl}, 0);
        chk("flush_mem_ctrl", {14'd0, bus.mem_ctrl}, 32'h2C004);
        idle_drain();

        // ---- stall_i freeze for 3 cycles ----
        drive(vecs[0].inst, 1'b1, 1'b0);
        tick();
        drive(vecs[5].inst, 1'b1, 1'b0);
        tick();
        drive(vecs[6].inst, 1'b1, 1'b0);
        tick();
        drive(enc(OP_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0), 1'b1, 1'b0);
        bus.stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("frz_ex_ctrl",  {14'd0, bus.ex_ctrl},  32'h21014);
            chk("frz_mem_ctrl", {14'd0, bus.mem_ctrl}, 32'h20014);
            chk("frz_wb_ctrl",  {14'd0, bus.wb_ctrl},  32'h200C4);
            chk("frz_wb_rd",    {27'd0, bus.wb_rd},    1);
        end
        bus.stall_i = 1'b0;
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("rel_ex_valid", {31'd0, bus.ex_valid}, 1);
        chk("rel_ex_ctrl",  {14'd0, bus.ex_ctrl},  32'h00240);
        chk("rel_mem_ctrl", {14'd0, bus.mem_ctrl}, 32'h21014);
        chk("rel_wb_ctrl",  {14'd0, bus.wb_ctrl},  32'h20014);

        // ---- reset mid-stream with RAW pending ----
        drive(vecs[0].inst, 1'b1, 1'b0);
        tick();
        drive(enc(OP_ARI_R, 5'd5, 3'd0, 5'd1, 5'd1), 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_hazard", {31'd0, bus.hazard_stall}, 0);
        tick();
        chk("rst_mid_ex_valid",  {31'd0, bus.ex_valid}, 0);
        chk("rst_mid_mem_valid", {31'd0, bus.mem_valid}, 0);
        chk("rst_mid_wb_valid",  {31'd0, bus.wb_valid}, 0);
        chk("rst_mid_mem_ctrl",  {14'd0, bus.mem_ctrl}, 0);
        chk("rst_mid_mem_rd",    {27'd0, bus.mem_rd}, 0);
        rst = 1'b0;
        drive(32'd0, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
